// File: rtl/fwd_hazard_unit_pkg.sv
// Shared ISA header for the forwarding/hazard slice: word and register-index
// widths, load opcodes, and the per-stage destination tag record.
package fwd_hazard_unit_pkg;

    localparam int WORD  = 32;
    localparam int REG_W = 5;

    // MIPS primary opcodes for the load family (LB/LH/LW/LBU/LHU)
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    // Destination tag carried alongside each of EX, MEM and WB
    typedef struct packed {
        logic [REG_W-1:0] dst;
        logic             regWrite;
        logic             isLoad;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // Decode helper so the ID stage derives idIsLoad from the same opcode list
    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // A tag only counts when it writes a real register; $0 is never forwarded
    function automatic logic tag_live(input tag_t t);
        return t.regWrite && (t.dst != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_select.sv
// Per-source forwarding mux: picks the youngest live writer of i_addr among
// EX, MEM and WB. A load sitting in EX cannot supply data yet, so it blocks
// the older stages and is reported as a load hit instead.
module fwd_select
    import fwd_hazard_unit_pkg::*;
(
    input  logic [REG_W-1:0] i_addr,
    input  logic             i_used,
    input  tag_t             i_exTag,
    input  tag_t             i_memTag,
    input  tag_t             i_wbTag,
    input  logic [WORD-1:0]  i_exResult,
    input  logic [WORD-1:0]  i_memResult,
    input  logic [WORD-1:0]  i_wbResult,
    output logic             o_fwd,
    output logic [WORD-1:0]  o_data,
    output logic             o_loadHit
);

    logic w_exHit;
    logic w_memHit;
    logic w_wbHit;

    assign w_exHit  = i_used && tag_live(i_exTag)  && (i_exTag.dst  == i_addr);
    assign w_memHit = i_used && tag_live(i_memTag) && (i_memTag.dst == i_addr);
    assign w_wbHit  = i_used && tag_live(i_wbTag)  && (i_wbTag.dst  == i_addr);

    // Priority select EX > MEM > WB; an EX load match suppresses older stages
    always_comb begin
        o_fwd     = 1'b0;
        o_data    = '0;
        o_loadHit = 1'b0;
        if (w_exHit) begin
            if (i_exTag.isLoad) begin
                o_loadHit = 1'b1;
            end else begin
                o_fwd  = 1'b1;
                o_data = i_exResult;
            end
        end else if (w_memHit) begin
            o_fwd  = 1'b1;
            o_data = i_memResult;
        end else if (w_wbHit) begin
            o_fwd  = 1'b1;
            o_data = i_wbResult;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the 5-stage core. Tracks
// destination tags in EX/MEM/WB, forwards to both ID sources, stalls ID one
// cycle on load-use, and counts stall cycles (saturating).
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rstN,
    input  logic             i_idValid,
    input  logic [REG_W-1:0] i_rsAddr,
    input  logic [REG_W-1:0] i_rtAddr,
    input  logic             i_rsUsed,
    input  logic             i_rtUsed,
    input  logic [REG_W-1:0] i_idDst,
    input  logic             i_idRegWrite,
    input  logic             i_idIsLoad,
    input  logic             i_flush,
    input  logic             i_hold,
    input  logic [WORD-1:0]  i_exResult,
    input  logic [WORD-1:0]  i_memResult,
    input  logic [WORD-1:0]  i_wbResult,
    output logic             o_rsFwd,
    output logic [WORD-1:0]  o_rsFwdData,
    output logic             o_rtFwd,
    output logic [WORD-1:0]  o_rtFwdData,
    output logic             o_stall,
    output logic [31:0]      o_stallCount
);

    tag_t        r_exTag;
    tag_t        r_memTag;
    tag_t        r_wbTag;
    logic [31:0] r_stallCount;

    logic w_rsUsed;
    logic w_rtUsed;
    logic w_rsLoadHit;
    logic w_rtLoadHit;
    logic w_bubble;
    tag_t w_idTag;

    assign w_rsUsed = i_rsUsed & i_idValid;
    assign w_rtUsed = i_rtUsed & i_idValid;

    fwd_select u_rs (
        .i_addr      (i_rsAddr),
        .i_used      (w_rsUsed),
        .i_exTag     (r_exTag),
        .i_memTag    (r_memTag),
        .i_wbTag     (r_wbTag),
        .i_exResult  (i_exResult),
        .i_memResult (i_memResult),
        .i_wbResult  (i_wbResult),
        .o_fwd       (o_rsFwd),
        .o_data      (o_rsFwdData),
        .o_loadHit   (w_rsLoadHit)
    );

    fwd_select u_rt (
        .i_addr      (i_rtAddr),
        .i_used      (w_rtUsed),
        .i_exTag     (r_exTag),
        .i_memTag    (r_memTag),
        .i_wbTag     (r_wbTag),
        .i_exResult  (i_exResult),
        .i_memResult (i_memResult),
        .i_wbResult  (i_wbResult),
        .o_fwd       (o_rtFwd),
        .o_data      (o_rtFwdData),
        .o_loadHit   (w_rtLoadHit)
    );

    // Flush squashes the ID instruction, so it also cancels any stall it caused
    assign o_stall  = !i_flush & i_idValid & (w_rsLoadHit | w_rtLoadHit);
    assign w_bubble = o_stall | i_flush | !i_idValid;
    assign w_idTag  = '{dst: i_idDst, regWrite: i_idRegWrite, isLoad: i_idIsLoad};

    // Advance tags EX->MEM->WB unless frozen; EX takes ID or a bubble
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_exTag  <= TAG_BUBBLE;
            r_memTag <= TAG_BUBBLE;
            r_wbTag  <= TAG_BUBBLE;
        end else if (!i_hold) begin
            r_wbTag  <= r_memTag;
            r_memTag <= r_exTag;
            r_exTag  <= w_bubble ? TAG_BUBBLE : w_idTag;
        end
    end

    // Saturating stall-cycle counter for performance reporting
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_stallCount <= '0;
        end else if (!i_hold && o_stall && (r_stallCount != 32'hFFFF_FFFF)) begin
            r_stallCount <= r_stallCount + 32'd1;
        end
    end

    assign o_stallCount = r_stallCount;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// checked against an in-flight instruction list model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        idValid, rsUsed, rtUsed, idRegWrite, idIsLoad, flush, hold;
    logic [4:0]  rsAddr, rtAddr, idDst;
    logic [31:0] exResult, memResult, wbResult;
    logic        rsFwd, rtFwd, stall;
    logic [31:0] rsFwdData, rtFwdData, stallCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .i_clk(clk), .i_rstN(rstN), .i_idValid(idValid),
        .i_rsAddr(rsAddr), .i_rtAddr(rtAddr), .i_rsUsed(rsUsed), .i_rtUsed(rtUsed),
        .i_idDst(idDst), .i_idRegWrite(idRegWrite), .i_idIsLoad(idIsLoad),
        .i_flush(flush), .i_hold(hold),
        .i_exResult(exResult), .i_memResult(memResult), .i_wbResult(wbResult),
        .o_rsFwd(rsFwd), .o_rsFwdData(rsFwdData), .o_rtFwd(rtFwd), .o_rtFwdData(rtFwdData),
        .o_stall(stall), .o_stallCount(stallCount)
    );

    // Model: list of in-flight writers, index 0 = youngest (EX)
    typedef struct { int dst; bit wr; bit ld; } ins_t;
    ins_t    m_pipe[3];
    longint  m_cnt;

    function automatic void m_src(input int a, input bit u, output bit f,
                                  output logic [31:0] d, output bit lh);
        bit found = 0;
        f = 0; d = 0; lh = 0;
        if (!u) return;
        for (int i = 0; i < 3; i++) begin
            if (!found && m_pipe[i].wr && m_pipe[i].dst != 0 && m_pipe[i].dst == a) begin
                found = 1;
                if (i == 0 && m_pipe[i].ld) lh = 1;
                else begin
                    f = 1;
                    d = (i == 0) ? exResult : (i == 1) ? memResult : wbResult;
                end
            end
        end
    endfunction

    function automatic bit m_stall();
        bit f; logic [31:0] d; bit lhs, lht;
        m_src(rsAddr, rsUsed & idValid, f, d, lhs);
        m_src(rtAddr, rtUsed & idValid, f, d, lht);
        return !flush && idValid && (lhs || lht);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 3; i++) m_pipe[i] = '{0, 0, 0};
        m_cnt = 0;
    endtask

    // One rising edge; model follows; returns 1ns after the edge
    task automatic tick();
        bit st = m_stall();
        @(posedge clk);
        if (!hold) begin
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            if (st || flush || !idValid) m_pipe[0] = '{0, 0, 0};
            else m_pipe[0] = '{int'(idDst), idRegWrite, idIsLoad};
            if (st && m_cnt != 64'hFFFF_FFFF) m_cnt++;
        end
        #1;
    endtask

    task automatic set_id(input bit v, input int rs, input bit rsu, input int rt,
                          input bit rtu, input int dst, input bit wr, input bit ld);
        idValid = v; rsAddr = rs[4:0]; rsUsed = rsu; rtAddr = rt[4:0]; rtUsed = rtu;
        idDst = dst[4:0]; idRegWrite = wr; idIsLoad = ld;
    endtask

    task automatic do_reset();
        rstN = 0; flush = 0; hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exResult = 0; memResult = 0; wbResult = 0;
        m_clear();
        #3 rstN = 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_id(1, 1, 1, 1, 1, 1, 1, 0);
        tick();
        set_id(1, 5, 1, 5, 1, 5, 1, 1);
        exResult = 32'h55; memResult = 32'h66; wbResult = 32'h77;
        rstN = 0; m_clear();
        #1;
        checks++;
        if ({rsFwd, rtFwd, stall} !== 3'b000 || rsFwdData !== 0 || rtFwdData !== 0) begin
            errors++;
            $display("FAIL reset_outputs: got fwd=%b/%b stall=%b data=%h/%h, want all 0",
                     rsFwd, rtFwd, stall, rsFwdData, rtFwdData);
        end
        checks++;
        if (stallCount !== 0) begin
            errors++; $display("FAIL reset_count: got %0d want 0", stallCount);
        end
        #3 rstN = 1;
        #1;
        checks++;
        if ({rsFwd, rtFwd, stall} !== 3'b000 || stallCount !== 0) begin
            errors++;
            $display("FAIL after_reset: got fwd=%b/%b stall=%b cnt=%0d, want 0",
                     rsFwd, rtFwd, stall, stallCount);
        end
    endtask

    task automatic test_ex_forward();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 1, 9, 1, 0, 0, 0);
        exResult = 32'h1234;
        #1;
        checks++;
        if (rsFwd !== 1 || rsFwdData !== 32'h1234 || stall !== 0 || rtFwd !== 0) begin
            errors++;
            $display("FAIL ex_forward: got fwd=%b data=%h stall=%b rtFwd=%b, want 1 1234 0 0",
                     rsFwd, rsFwdData, stall, rtFwd);
        end
        // rs == rt both used: identical values on both ports
        set_id(1, 3, 1, 3, 1, 0, 0, 0);
        #1;
        checks++;
        if (rtFwd !== 1 || rtFwdData !== 32'h1234 || rsFwdData !== 32'h1234) begin
            errors++;
            $display("FAIL rs_eq_rt: got rs=%h rt=%h rtFwd=%b, want 1234 1234 1",
                     rsFwdData, rtFwdData, rtFwd);
        end
    endtask

    task automatic test_priority();
        do_reset();
        set_id(1, 0, 0, 0, 0, 7, 1, 0);
        tick();
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(1, 0, 0, 7, 1, 0, 0, 0);
        memResult = 32'hAAAA; wbResult = 32'hBBBB; exResult = 32'hCCCC;
        #1;
        checks++;
        if (rtFwd !== 1 || rtFwdData !== 32'hAAAA) begin
            errors++;
            $display("FAIL priority_mem_wb: got fwd=%b data=%h, want 1 aaaa", rtFwd, rtFwdData);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 1, 0, 0, 9, 1, 0);
        exResult = 32'h5555; memResult = 32'h1111;
        #1;
        checks++;
        if (stall !== 1 || rsFwd !== 0 || rsFwdData !== 0) begin
            errors++;
            $display("FAIL load_use_stall: got stall=%b fwd=%b data=%h, want 1 0 0",
                     stall, rsFwd, rsFwdData);
        end
        tick();
        memResult = 32'hDEAD;
        #1;
        checks++;
        if (stall !== 0 || rsFwd !== 1 || rsFwdData !== 32'hDEAD || stallCount !== 1) begin
            errors++;
            $display("FAIL load_use_after: got stall=%b fwd=%b data=%h cnt=%0d, want 0 1 dead 1",
                     stall, rsFwd, rsFwdData, stallCount);
        end
    endtask

    task automatic test_zero_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 0, 0);
        exResult = 32'h4321;
        #1;
        checks++;
        if (rsFwd !== 0 || rtFwd !== 0 || rsFwdData !== 0) begin
            errors++;
            $display("FAIL zero_reg: got fwd=%b/%b data=%h, want 0 0 0", rsFwd, rtFwd, rsFwdData);
        end
        set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 1, 0, 0, 9, 1, 0);
        flush = 1;
        #1;
        checks++;
        if (stall !== 0) begin
            errors++; $display("FAIL flush_stall: got stall=%b want 0", stall);
        end
        tick();
        flush = 0;
        set_id(1, 9, 1, 4, 1, 0, 0, 0);
        memResult = 32'hBEEF;
        #1;
        checks++;
        if (rsFwd !== 0 || rtFwd !== 1 || rtFwdData !== 32'hBEEF || stallCount !== 0) begin
            errors++;
            $display("FAIL flush_bubble: got rsFwd=%b rtFwd=%b rt=%h cnt=%0d, want 0 1 beef 0",
                     rsFwd, rtFwd, rtFwdData, stallCount);
        end
    endtask

    task automatic test_hold();
        do_reset();
        set_id(1, 0, 0, 0, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 1, 0, 0, 0, 0, 0);
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (stall !== 1 || stallCount !== 0) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: got stall=%b cnt=%0d, want 1 0", i, stall, stallCount);
            end
        end
        hold = 0;
        tick();
        memResult = 32'hDEAD;
        #1;
        checks++;
        if (stall !== 0 || stallCount !== 1 || rsFwdData !== 32'hDEAD) begin
            errors++;
            $display("FAIL hold_release: got stall=%b cnt=%0d data=%h, want 0 1 dead",
                     stall, stallCount, rsFwdData);
        end
    endtask

    task automatic test_reset_midstall();
        do_reset();
        set_id(1, 0, 0, 0, 0, 6, 1, 1);
        tick();
        set_id(1, 0, 0, 6, 1, 0, 0, 0);
        #1;
        checks++;
        if (stall !== 1) begin
            errors++; $display("FAIL midstall_setup: got stall=%b want 1", stall);
        end
        rstN = 0; m_clear();
        #1;
        checks++;
        if (stall !== 0 || stallCount !== 0) begin
            errors++;
            $display("FAIL midstall_reset: got stall=%b cnt=%0d, want 0 0", stall, stallCount);
        end
        rstN = 1;
        @(negedge clk);
    endtask

    task automatic test_random();
        bit f_rs, f_rt, lh; logic [31:0] d_rs, d_rt; bit st;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            exResult = $urandom; memResult = $urandom; wbResult = $urandom;
            #1;
            m_src(rsAddr, rsUsed & idValid, f_rs, d_rs, lh);
            m_src(rtAddr, rtUsed & idValid, f_rt, d_rt, lh);
            st = m_stall();
            checks++;
            if (rsFwd !== f_rs || rsFwdData !== d_rs || rtFwd !== f_rt || rtFwdData !== d_rt ||
                stall !== st || stallCount !== m_cnt[31:0]) begin
                errors++;
                $display("FAIL random[%0d]: got rs=%b/%h rt=%b/%h st=%b cnt=%0d want rs=%b/%h rt=%b/%h st=%b cnt=%0d",
                         n, rsFwd, rsFwdData, rtFwd, rtFwdData, stall, stallCount,
                         f_rs, d_rs, f_rt, d_rt, st, m_cnt);
            end
            tick();
        end
        hold = 0; flush = 0;
    endtask

    initial begin
        rstN = 0; flush = 0; hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        exResult = 0; memResult = 0; wbResult = 0;
        m_clear();
        #12 rstN = 1;
        @(negedge clk);
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_zero_flush();
        test_hold();
        test_reset_midstall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Producer side of the operand-forwarding interface: tracks destination registers of the instructions in flight in EX, MEM and WB, and drives `rsFwd`/`rsFwdData` and `rtFwd`/`rtFwdData` to the ID-stage operand selector. Detects load-use hazards, requests a one-cycle ID stall, and inserts bubbles on stall or flush. Sits beside the ID/EX pipeline register in the 5-stage MIPS core, with a free-running stall counter for performance reporting.

## Interface
- Parameters: none. Word = `WORD` (32 bits) and register index = 5 bits, both from the shared ISA header.
- `clk`  in  1  core clock, rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `idValid`  in  1  ID holds a real instruction.
- `rsAddr`, `rtAddr`  in  5  ID source register indices.
- `rsUsed`, `rtUsed`  in  1  ID instruction actually reads rs / rt.
- `idDst`  in  5  ID destination register.
- `idRegWrite`  in  1  ID instruction writes `idDst`.
- `idIsLoad`  in  1  ID instruction is LB/LBU/LH/LHU/LW.
- `flush`  in  1  squash the ID instruction (taken branch or jump).
- `hold`  in  1  global pipeline freeze (memory busy).
- `exResult`  in  WORD  ALU output of the EX instruction (combinational).
- `memResult`  in  WORD  MEM-stage result (load data for loads, ALU result otherwise).
- `wbResult`  in  WORD  WB-stage write data.
- `rsFwd`, `rtFwd`  out  1  forward valid.
- `rsFwdData`, `rtFwdData`  out  WORD  forwarded value.
- `stall`  out  1  ID/IF must hold; EX receives a bubble.
- `stallCount`  out  32  saturating count of stall cycles.

## Operation
- Three tag registers, EX, MEM and WB. Each tag holds {dst[4:0], regWrite, isLoad}.
- A tag is live when `regWrite` is 1 and `dst` is not 0. Register 0 is never forwarded.
- Per source (rs shown; rt is identical), with `used = rsUsed & idValid`:
  - EX tag live, matches `rsAddr`, and is not a load: `rsFwd`=1, data = `exResult`.
  - Otherwise MEM tag live and matches: `rsFwd`=1, data = `memResult`.
  - Otherwise WB tag live and matches: `rsFwd`=1, data = `wbResult`.
  - Otherwise `rsFwd`=0, data = 0.
- Priority is EX > MEM > WB, so the youngest writer wins.
- Load-use: `stall` = !`flush` & (EX tag live & isLoad & (rs match & rsUsed | rt match & rtUsed)) & `idValid`.
- A load match in EX suppresses forwarding from the older MEM and WB tags for that source.
- Tag advance on the rising edge when `hold`=0:
  - WB ← MEM, MEM ← EX.
  - EX ← ID fields, or a bubble (all zero) when `stall` | `flush` | !`idValid`.
- `hold`=1 freezes all tags and `stallCount`. Outputs are still recomputed combinationally.
- `stallCount` increments on each edge where `stall`=1 and `hold`=0, and saturates at 0xFFFFFFFF.

## Timing
- Forward and stall outputs are combinational from the tags plus ID inputs: zero-cycle latency, no registered outputs.
- A load in EX causes exactly one stall cycle. On the next edge the load moves to MEM and forwarding comes from `memResult`.
- Reset (`rstN`=0, asynchronous) clears all tags and `stallCount`. While in reset and right after it: `rsFwd`=`rtFwd`=0, data outputs = 0, `stall`=0, `stallCount`=0.
- Reset in mid-stall clears the stall immediately, with no waiting for a clock edge.
- `flush` together with `stall`: flush wins, `stall`=0, a bubble enters EX, and `stallCount` does not increment.
- `hold` together with `flush`: hold wins. Upstream keeps `flush` asserted until `hold` drops.
- rs = rt with both used: both ports forward the same value.

## Structure
- Tag record fields and the load-opcode list belong in the shared ISA header. The opcode macros are reused.
- One sub-module, `fwd_select`, instantiated twice (rs and rt). It takes the three tags and the three stage results and returns fwd, data and loadHit.

## Test plan
- Reset: assert `rstN`=0 with `rsAddr`=`idDst`=5 live in ID → all outputs 0; `stallCount`=0.
- EX forward: ADDI $3 enters EX with `exResult`=0x1234; ID reads rs=$3 → `rsFwd`=1, `rsFwdData`=0x1234, `stall`=0.
- Priority: $7 written in both MEM (0xAAAA) and WB (0xBBBB); ID rt=$7 → `rtFwdData`=0xAAAA.
- Load-use: LW $4 in EX; ID rs=$4 → `stall`=1 for 1 cycle; next cycle `rsFwdData`=`memResult`=0xDEAD; `stallCount`=1.
- $0 destination: ADD $0 in EX; ID rs=$0 → `rsFwd`=0. Flush during a load-use → `stall`=0, a bubble enters EX, `stallCount` unchanged.
- Hold: `hold`=1 for 3 cycles with LW $4 in EX → tags frozen, `stall` stays 1, `stallCount` unchanged until `hold` drops.
